// File: rtl/track_section_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : track_pkg
// Description : Shared types, default parameter values and the round-robin
//               pick helper for the track section arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package track_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        SETTLE   = 2'b01,
        OCCUPIED = 2'b10,
        FAULT    = 2'b11
    } state_t;

    localparam int c_DEF_NUM_TRAINS      = 4;
    localparam int c_DEF_DEBOUNCE_CYCLES = 4;
    localparam int c_DEF_SETTLE_CYCLES   = 8;
    localparam int c_DEF_TIMEOUT_CYCLES  = 1000;

    // Widest request mask the pick helper accepts; callers zero-extend.
    localparam int c_MAX_TRAINS = 32;

    // First set bit of mask[n-1:0], searching upward from last+1 modulo n.
    // The loop walks the distances backwards so the nearest hit is written
    // last and wins. Returns 0 when the mask is empty.
    function automatic int rr_pick(input logic [c_MAX_TRAINS-1:0] mask,
                                   input int last,
                                   input int n);
        int idx;
        rr_pick = 0;
        for (int k = n; k >= 1; k--) begin
            idx = (last + k) % n;
            if (mask[idx]) begin
                rr_pick = idx;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/track_section_arbiter_sensor_debounce.sv
`default_nettype none
// ============================================================================
// Module      : sensor_debounce
// Description : Two-flop synchroniser followed by a debounce counter for one
//               raw track sensor. The debounced level flips on the
//               DEBOUNCE_CYCLES-th consecutive synchronised sample that
//               differs from it; a rising flip produces a one-cycle pulse.
//               Raw step to pulse latency is 2 + DEBOUNCE_CYCLES cycles.
// Ports       : clk      - system clock
//               reset_n  - asynchronous active-low reset
//               i_raw    - raw asynchronous sensor
//               o_level  - debounced level
//               o_rise   - one-cycle pulse on a debounced rising edge
// Revision    : 1.0 - initial release
// ============================================================================
module sensor_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_raw,
    output logic o_level,
    output logic o_rise
);

    localparam int c_CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic            r_rise;
    logic [c_CW-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_level <= 1'b0;
            r_rise  <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            if (r_sync2 != r_level) begin
                // r_cnt holds how many differing samples were already seen.
                if (r_cnt == c_CW'(DEBOUNCE_CYCLES - 1)) begin
                    r_level <= r_sync2;
                    r_rise  <= r_sync2;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_level = r_level;
    assign o_rise  = r_rise;

endmodule
`default_nettype wire

// File: rtl/track_section_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : track_section_arbiter
// Description : Interlock for one shared single-track section fed by
//               NUM_TRAINS approaches. Debounces approach/exit sensors,
//               grants the section round-robin, drives the route switch,
//               holds waiting trains and latches a timeout fault.
// Ports       : clk, reset_n     - clock, asynchronous active-low reset
//               i_approach       - raw approach sensors, one per train
//               i_depart         - raw exit sensors, one per train
//               i_clear_fault    - leaves FAULT
//               o_drive          - 1 = train runs, 0 = train held
//               o_route_sel      - switch position (routed train index)
//               o_busy           - section granted or settling
//               o_owner          - current grantee, valid while o_busy
//               o_fault          - timeout fault latched
//               o_spurious       - one-cycle pulse on an unexpected depart
// Revision    : 1.0 - initial release
// ============================================================================
module track_section_arbiter
    import track_pkg::*;
#(
    parameter int NUM_TRAINS      = c_DEF_NUM_TRAINS,
    parameter int DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
    parameter int SETTLE_CYCLES   = c_DEF_SETTLE_CYCLES,
    parameter int TIMEOUT_CYCLES  = c_DEF_TIMEOUT_CYCLES,
    parameter int IDX_W           = $clog2(NUM_TRAINS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_TRAINS-1:0] i_approach,
    input  logic [NUM_TRAINS-1:0] i_depart,
    input  logic                  i_clear_fault,
    output logic [NUM_TRAINS-1:0] o_drive,
    output logic [IDX_W-1:0]      o_route_sel,
    output logic                  o_busy,
    output logic [IDX_W-1:0]      o_owner,
    output logic                  o_fault,
    output logic                  o_spurious
);

    localparam int c_CNT_MAX = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);

    // ------------------------------------------------------------------
    // Sensor front end: only the rising-edge events feed the arbiter; the
    // debounced levels are not needed here.
    // ------------------------------------------------------------------
    logic [NUM_TRAINS-1:0] w_appr_ev;
    logic [NUM_TRAINS-1:0] w_dep_ev;
    logic [NUM_TRAINS-1:0] w_unused_appr_level;
    logic [NUM_TRAINS-1:0] w_unused_dep_level;

    generate
        for (genvar gi = 0; gi < NUM_TRAINS; gi++) begin : g_sensor
            sensor_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_appr (
                .clk     (clk),
                .reset_n (reset_n),
                .i_raw   (i_approach[gi]),
                .o_level (w_unused_appr_level[gi]),
                .o_rise  (w_appr_ev[gi])
            );
            sensor_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_dep (
                .clk     (clk),
                .reset_n (reset_n),
                .i_raw   (i_depart[gi]),
                .o_level (w_unused_dep_level[gi]),
                .o_rise  (w_dep_ev[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and registered outputs
    // ------------------------------------------------------------------
    state_t                r_state;
    state_t                w_state_n;
    logic [c_CNT_W-1:0]    r_cnt;
    logic [c_CNT_W-1:0]    w_cnt_n;
    logic [c_CNT_W-1:0]    w_cnt_dec;
    logic [NUM_TRAINS-1:0] r_pending;
    logic [NUM_TRAINS-1:0] w_pending_n;
    logic [NUM_TRAINS-1:0] r_drive;
    logic [NUM_TRAINS-1:0] w_drive_n;
    logic [NUM_TRAINS-1:0] w_legit_dep;
    logic [IDX_W-1:0]      r_owner;
    logic [IDX_W-1:0]      w_owner_n;
    logic [IDX_W-1:0]      r_route;
    logic [IDX_W-1:0]      w_route_n;
    logic [IDX_W-1:0]      r_rr_last;
    logic [IDX_W-1:0]      w_rr_last_n;
    logic [IDX_W-1:0]      w_pick;
    logic                  r_busy;
    logic                  w_busy_n;
    logic                  r_fault;
    logic                  w_fault_n;
    logic                  r_spur;
    logic                  w_spur_n;

    // Shared settle/timeout counter, decrement saturating at zero.
    assign w_cnt_dec = (r_cnt == '0) ? '0 : r_cnt - 1'b1;

    // Only the owner's depart while OCCUPIED is expected; anything else
    // (including the owner departing while the switch is still settling)
    // is flagged.
    assign w_legit_dep = (r_state == OCCUPIED) ? (NUM_TRAINS'(1) << r_owner) : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_pending <= '0;
            r_drive   <= '1;
            r_owner   <= '0;
            r_route   <= '0;
            r_rr_last <= IDX_W'(NUM_TRAINS - 1);
            r_busy    <= 1'b0;
            r_fault   <= 1'b0;
            r_spur    <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_cnt     <= w_cnt_n;
            r_pending <= w_pending_n;
            r_drive   <= w_drive_n;
            r_owner   <= w_owner_n;
            r_route   <= w_route_n;
            r_rr_last <= w_rr_last_n;
            r_busy    <= w_busy_n;
            r_fault   <= w_fault_n;
            r_spur    <= w_spur_n;
        end
    end

    always_comb begin
        w_state_n   = r_state;
        w_cnt_n     = r_cnt;
        w_owner_n   = r_owner;
        w_route_n   = r_route;
        w_rr_last_n = r_rr_last;
        w_busy_n    = r_busy;
        w_fault_n   = r_fault;
        w_spur_n    = |(w_dep_ev & ~w_legit_dep);
        w_drive_n   = '1;
        // Approach events are collected in every state but FAULT, so a
        // request arriving together with the owner's depart is arbitrated
        // in the following IDLE cycle.
        w_pending_n = (r_state == FAULT) ? r_pending : (r_pending | w_appr_ev);
        w_pick      = IDX_W'(rr_pick(c_MAX_TRAINS'(w_pending_n), int'(r_rr_last), NUM_TRAINS));

        case (r_state)
            IDLE: begin
                if (w_pending_n != '0) begin
                    w_owner_n   = w_pick;
                    w_route_n   = w_pick;
                    w_rr_last_n = w_pick;
                    w_busy_n    = 1'b1;
                    if (SETTLE_CYCLES == 0) begin
                        w_state_n           = OCCUPIED;
                        w_pending_n[w_pick] = 1'b0;
                        w_cnt_n             = c_CNT_W'(TIMEOUT_CYCLES);
                    end else begin
                        w_state_n = SETTLE;
                        w_cnt_n   = c_CNT_W'(SETTLE_CYCLES);
                    end
                end
            end
            SETTLE: begin
                if (w_cnt_dec == '0) begin
                    w_state_n            = OCCUPIED;
                    w_pending_n[r_owner] = 1'b0;
                    w_cnt_n              = c_CNT_W'(TIMEOUT_CYCLES);
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            OCCUPIED: begin
                // Owner depart takes priority over an expiring timeout.
                if (w_dep_ev[r_owner]) begin
                    w_state_n = IDLE;
                    w_busy_n  = 1'b0;
                end else if (w_cnt_dec == '0) begin
                    w_state_n = FAULT;
                    w_fault_n = 1'b1;
                    w_cnt_n   = '0;
                end else begin
                    w_cnt_n = w_cnt_dec;
                end
            end
            FAULT: begin
                if (i_clear_fault) begin
                    w_state_n   = IDLE;
                    w_pending_n = '0;
                    w_busy_n    = 1'b0;
                    w_fault_n   = 1'b0;
                end
            end
            default: ;
        endcase

        // Drive is derived from the post-edge state so it changes on the
        // same edge as the state and pending bits it depends on.
        for (int i = 0; i < NUM_TRAINS; i++) begin
            w_drive_n[i] = !((w_state_n == FAULT)
                          || (w_pending_n[i] && !((w_state_n == OCCUPIED) && (w_owner_n == IDX_W'(i))))
                          || ((w_state_n == SETTLE) && (w_owner_n == IDX_W'(i))));
        end
    end

    assign o_drive     = r_drive;
    assign o_route_sel = r_route;
    assign o_busy      = r_busy;
    assign o_owner     = r_owner;
    assign o_fault     = r_fault;
    assign o_spurious  = r_spur;

endmodule
`default_nettype wire

// File: tb/tb_track_section_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_track_section_arbiter
// Description : Self-checking bench for track_section_arbiter (N=4,
//               DEBOUNCE=4, SETTLE=8, TIMEOUT=1000). Expected output records
//               are queued when stimulus is applied and popped for
//               comparison after the known latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_track_section_arbiter;

    localparam int c_N       = 4;
    localparam int c_TIMEOUT = 1000;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] approach;
    logic [3:0] depart;
    logic       clear_fault;
    logic [3:0] drive;
    logic [1:0] route_sel;
    logic       busy;
    logic [1:0] owner;
    logic       fault;
    logic       spurious;

    always #5 clk = ~clk;

    track_section_arbiter #(
        .NUM_TRAINS      (c_N),
        .DEBOUNCE_CYCLES (4),
        .SETTLE_CYCLES   (8),
        .TIMEOUT_CYCLES  (c_TIMEOUT)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_approach    (approach),
        .i_depart      (depart),
        .i_clear_fault (clear_fault),
        .o_drive       (drive),
        .o_route_sel   (route_sel),
        .o_busy        (busy),
        .o_owner       (owner),
        .o_fault       (fault),
        .o_spurious    (spurious)
    );

    typedef struct {
        string      name;
        logic [3:0] drv;
        logic [1:0] rte;
        logic       bsy;
        logic       flt;
        logic       spr;
    } exp_t;

    typedef struct {
        string      name;
        logic [3:0] a;
        logic [3:0] d;
        int         n;
        logic [3:0] drv;
        logic [1:0] rte;
        logic       bsy;
    } vec_t;

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic expect_out(input string nm, input logic [3:0] d, input logic [1:0] r,
                              input logic b, input logic f, input logic s);
        exp_t e;
        e.name = nm; e.drv = d; e.rte = r; e.bsy = b; e.flt = f; e.spr = s;
        sb.push_back(e);
    endtask

    task automatic compare_out();
        exp_t e;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL scoreboard: no expected record queued");
        end else begin
            e = sb.pop_front();
            chk({e.name, " drive"},    32'(drive),     32'(e.drv));
            chk({e.name, " route"},    32'(route_sel), 32'(e.rte));
            chk({e.name, " busy"},     32'(busy),      32'(e.bsy));
            chk({e.name, " fault"},    32'(fault),     32'(e.flt));
            chk({e.name, " spurious"}, 32'(spurious),  32'(e.spr));
            if (e.bsy) chk({e.name, " owner"}, 32'(owner), 32'(e.rte));
        end
    endtask

    // Raw pulse long enough to pass the debouncer, then one more edge so
    // the arbiter has reacted to the resulting event.
    task automatic sense_chk(input string nm, input logic [3:0] a, input logic [3:0] d,
                             input logic [3:0] drv, input logic [1:0] r,
                             input logic b, input logic f, input logic s);
        expect_out(nm, drv, r, b, f, s);
        approach = a;
        depart   = d;
        tick(6);
        approach = '0;
        depart   = '0;
        tick(1);
        compare_out();
    endtask

    task automatic wait_chk(input string nm, input int n, input logic [3:0] drv,
                            input logic [1:0] r, input logic b, input logic f, input logic s);
        expect_out(nm, drv, r, b, f, s);
        tick(n);
        compare_out();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[7];
        vt[0] = '{"t1_latency",  4'b0100, 4'b0000, 6,  4'b1111, 2'd0, 1'b0};
        vt[1] = '{"t1_grant",    4'b0100, 4'b0000, 1,  4'b1011, 2'd2, 1'b1};
        vt[2] = '{"t1_settling", 4'b0100, 4'b0000, 7,  4'b1011, 2'd2, 1'b1};
        vt[3] = '{"t1_release",  4'b0100, 4'b0000, 1,  4'b1111, 2'd2, 1'b1};
        vt[4] = '{"t1_dep_lat",  4'b0000, 4'b0100, 6,  4'b1111, 2'd2, 1'b1};
        vt[5] = '{"t1_leave",    4'b0000, 4'b0000, 1,  4'b1111, 2'd2, 1'b0};
        vt[6] = '{"t1_quiet",    4'b0000, 4'b0000, 10, 4'b1111, 2'd2, 1'b0};

        reset_n     = 1'b0;
        approach    = '0;
        depart      = '0;
        clear_fault = 1'b0;
        tick(3);
        wait_chk("reset", 0, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("reset owner", 32'(owner), 32'd0);
        reset_n = 1'b1;
        tick(2);

        // Single train, table driven.
        for (int i = 0; i < 7; i++) begin
            approach = vt[i].a;
            depart   = vt[i].d;
            expect_out(vt[i].name, vt[i].drv, vt[i].rte, vt[i].bsy, 1'b0, 1'b0);
            tick(vt[i].n);
            compare_out();
        end

        // Fairness: make train 0 the last grantee, then request 0, 1, 3.
        sense_chk("f_g0",  4'b0001, 4'b0000, 4'b1110, 2'd0, 1'b1, 1'b0, 1'b0);
        wait_chk ("f_o0",  8,                4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
        sense_chk("f_req", 4'b1011, 4'b0000, 4'b0101, 2'd0, 1'b1, 1'b0, 1'b0);
        sense_chk("f_d0",  4'b0000, 4'b0001, 4'b0100, 2'd0, 1'b0, 1'b0, 1'b0);
        wait_chk ("f_g1",  1,                4'b0100, 2'd1, 1'b1, 1'b0, 1'b0);
        wait_chk ("f_o1",  8,                4'b0110, 2'd1, 1'b1, 1'b0, 1'b0);
        sense_chk("f_d1",  4'b0000, 4'b0010, 4'b0110, 2'd1, 1'b0, 1'b0, 1'b0);
        wait_chk ("f_g3",  1,                4'b0110, 2'd3, 1'b1, 1'b0, 1'b0);
        wait_chk ("f_o3",  8,                4'b1110, 2'd3, 1'b1, 1'b0, 1'b0);
        sense_chk("f_d3",  4'b0000, 4'b1000, 4'b1110, 2'd3, 1'b0, 1'b0, 1'b0);
        wait_chk ("f_g0b", 1,                4'b1110, 2'd0, 1'b1, 1'b0, 1'b0);
        wait_chk ("f_o0b", 8,                4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
        sense_chk("f_d0b", 4'b0000, 4'b0001, 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);

        // Owner 1 in OCCUPIED.
        sense_chk("c_g1", 4'b0010, 4'b0000, 4'b1101, 2'd1, 1'b1, 1'b0, 1'b0);
        wait_chk ("c_o1", 8,                4'b1111, 2'd1, 1'b1, 1'b0, 1'b0);

        // Three-cycle approach glitch must not create a request.
        expect_out("g_glitch", 4'b1111, 2'd1, 1'b1, 1'b0, 1'b0);
        approach = 4'b0100;
        tick(3);
        approach = '0;
        tick(10);
        compare_out();

        // Depart from a non-owner: one-cycle spurious pulse only.
        sense_chk("s_dep3", 4'b0000, 4'b1000, 4'b1111, 2'd1, 1'b1, 1'b0, 1'b1);
        wait_chk ("s_end",  1,                4'b1111, 2'd1, 1'b1, 1'b0, 1'b0);

        // Contention during occupancy.
        sense_chk("c_req0", 4'b0001, 4'b0000, 4'b1110, 2'd1, 1'b1, 1'b0, 1'b0);
        sense_chk("c_d1",   4'b0000, 4'b0010, 4'b1110, 2'd1, 1'b0, 1'b0, 1'b0);
        wait_chk ("c_g0",   1,                4'b1110, 2'd0, 1'b1, 1'b0, 1'b0);
        wait_chk ("c_o0",   8,                4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);

        // Timeout: owner 0 never departs.
        wait_chk ("t_pre",  c_TIMEOUT - 1,    4'b1111, 2'd0, 1'b1, 1'b0, 1'b0);
        wait_chk ("t_flt",  1,                4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
        sense_chk("t_ign",  4'b0100, 4'b0000, 4'b0000, 2'd0, 1'b1, 1'b1, 1'b0);
        expect_out("t_clr", 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
        clear_fault = 1'b1;
        tick(1);
        clear_fault = 1'b0;
        compare_out();
        wait_chk ("t_idle", 10,               4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in SETTLE.
        sense_chk("r_g2", 4'b0100, 4'b0000, 4'b1011, 2'd2, 1'b1, 1'b0, 1'b0);
        tick(3);
        #2;
        expect_out("r_async", 4'b1111, 2'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b0;
        #1;
        compare_out();
        chk("r_async owner", 32'(owner), 32'd0);
        tick(2);
        reset_n = 1'b1;
        tick(1);
        // rr_last back at 3: requests 0 and 3 resolve to 0.
        sense_chk("r_rr", 4'b1001, 4'b0000, 4'b0110, 2'd0, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
